// File: rtl/snake_game_ctrl.sv
// Snake game session controller: life-cycle FSM, score-scaled move tick,
// and a 2-deep turn request queue feeding snake_direction.
//
// state | meaning
// IDLE  | waiting for first start, no ticks
// PLAY  | counting toward game_tick, turn requests queued
// PAUSE | counter frozen, turn requests ignored
// OVER  | datapath reported game over, queue flushed, waiting for restart
module snake_game_ctrl #(
  parameter int unsigned BASE_TICK = 10000000,
  parameter int unsigned STEP_TICK = 500000,
  parameter int unsigned MIN_TICK  = 2000000,
  parameter int unsigned CNT_W     = 24
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       game_over,
  input  logic [7:0] score,
  output logic       game_tick,
  output logic [1:0] snake_direction,
  output logic       game_rst,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } state_t;

  localparam logic [31:0] BASE_W  = 32'(BASE_TICK);
  localparam logic [31:0] MIN_W   = 32'(MIN_TICK);
  localparam logic [31:0] STEP_W  = 32'(STEP_TICK);
  localparam logic [31:0] SPAN_W  = BASE_W - MIN_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d;
  logic             rst_q, rst_d;
  logic [1:0]       q0_q, q0_d, q1_q, q1_d;
  logic [1:0]       qcnt_q, qcnt_d;
  logic [5:0]       prev_q, prev_d;

  logic [5:0]  btn_now, btn_edge;
  logic        st_e, pa_e, up_e, dn_e, lf_e, rt_e;
  logic [31:0] reduce, period;
  logic        due, flush, restart;
  logic [1:0]  req, ref_dir, newest;
  logic        req_v, pop, push;

  assign btn_now  = {btn_start, btn_pause, btn_up, btn_down, btn_left, btn_right};
  assign prev_d   = btn_now;
  assign btn_edge = btn_now & ~prev_q;
  assign {st_e, pa_e, up_e, dn_e, lf_e, rt_e} = btn_edge;

  // Tick period from score; the subtraction is only taken when it stays above the floor.
  always_comb begin
    reduce = 32'(score) * STEP_W;
    if (reduce >= SPAN_W) period = MIN_W;
    else                  period = BASE_W - reduce;
    due = (32'(cnt_q) >= (period - 32'd1));
  end

  // Life-cycle next state, tick counter and tick strobe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_d     = 1'b0;
    game_tick = 1'b0;
    flush     = 1'b0;
    restart   = 1'b0;
    case (state_q)
      IDLE: if (st_e) restart = 1'b1;
      PLAY: begin
        if (game_over)   state_d = OVER;
        else if (pa_e)   state_d = PAUSE;
        else if (due) begin
          game_tick = 1'b1;
          cnt_d     = '0;
        end else         cnt_d = cnt_q + CNT_ONE;
      end
      PAUSE: begin
        if (st_e) restart = 1'b1;
        else if (pa_e) begin
          // Counting restarts in the resume cycle itself.
          state_d = PLAY;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      OVER: begin
        flush = 1'b1;
        if (st_e) restart = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (restart) begin
      state_d = PLAY;
      cnt_d   = '0;
      rst_d   = 1'b1;
      flush   = 1'b1;
    end
  end

  // Turn request filtering and the 2-entry FIFO; the head is applied on tick.
  always_comb begin
    req_v = up_e | dn_e | lf_e | rt_e;
    if (up_e)      req = 2'b01;
    else if (dn_e) req = 2'b11;
    else if (lf_e) req = 2'b10;
    else           req = 2'b00;
    newest  = (qcnt_q == 2'd2) ? q1_q : q0_q;
    ref_dir = (qcnt_q != 2'd0) ? newest : dir_q;
    pop     = game_tick && (qcnt_q != 2'd0);
    push    = (state_q == PLAY) && req_v && (req != ref_dir) &&
              (req != (ref_dir ^ 2'b10)) && ((qcnt_q != 2'd2) || pop);
    dir_d  = dir_q;
    q0_d   = q0_q;
    q1_d   = q1_q;
    qcnt_d = qcnt_q;
    if (pop) dir_d = q0_q;
    if (restart) dir_d = 2'b00;
    if (flush) qcnt_d = 2'd0;
    else begin
      case ({push, pop})
        2'b10: begin
          if (qcnt_q == 2'd0) q0_d = req;
          else                q1_d = req;
          qcnt_d = qcnt_q + 2'd1;
        end
        2'b01: begin
          q0_d   = q1_q;
          qcnt_d = qcnt_q - 2'd1;
        end
        2'b11: begin
          if (qcnt_q == 2'd1) q0_d = req;
          else begin
            q0_d = q1_q;
            q1_d = req;
          end
        end
        default: ;
      endcase
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 2'b00;
      rst_q   <= 1'b0;
      q0_q    <= 2'b00;
      q1_q    <= 2'b00;
      qcnt_q  <= 2'd0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      rst_q   <= rst_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
      qcnt_q  <= qcnt_d;
      prev_q  <= prev_d;
    end
  end

  assign snake_direction = dir_q;
  assign game_rst        = rst_q;
  assign state           = state_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: per-cycle reference model via scoreboard,
// table of turn-queue cases, and directed life-cycle sequences.
module tb_snake_game_ctrl;

  localparam int BASE = 20;
  localparam int STEP = 2;
  localparam int MINT = 8;

  logic clk_100MHz = 1'b0;
  logic reset = 1'b0;
  logic btn_start = 0, btn_pause = 0, btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
  logic game_over = 0;
  logic [7:0] score = 8'd0;
  logic game_tick, game_rst;
  logic [1:0] snake_direction, state;

  snake_game_ctrl #(.BASE_TICK(BASE), .STEP_TICK(STEP), .MIN_TICK(MINT), .CNT_W(8)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .btn_start(btn_start), .btn_pause(btn_pause),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .game_over(game_over), .score(score), .game_tick(game_tick),
    .snake_direction(snake_direction), .game_rst(game_rst), .state(state)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    logic [1:0] st;
    logic       tick;
    logic       rst;
    logic [1:0] dir;
  } exp_t;

  typedef struct {
    logic [3:0] m1, m2, m3;   // {up,down,left,right}
    logic [1:0] e1, e2, e3;   // direction after ticks 1..3
  } turn_t;

  int n_assert = 0;
  int n_fail   = 0;
  exp_t sb[$];
  logic last_tick;

  // reference model state
  int         m_state, m_cnt;
  logic       m_rst;
  logic [1:0] m_dir;
  logic [1:0] mq[$];
  logic [5:0] m_prev;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_rst = 0; m_dir = 2'b00; m_prev = '0;
    mq.delete();
    sb.delete();
  endtask

  task automatic model_cycle(output exp_t e);
    logic [5:0] now, ed;
    int p, n_state, n_cnt;
    logic n_rst, tick, restart, flush, rv, popping, accept;
    logic [1:0] n_dir, r, refd;
    now = {btn_start, btn_pause, btn_up, btn_down, btn_left, btn_right};
    ed = now & ~m_prev;
    p = BASE - int'(score) * STEP;
    if (p < MINT) p = MINT;
    n_state = m_state; n_cnt = m_cnt; n_dir = m_dir; n_rst = 0;
    tick = 0; restart = 0; flush = 0;
    case (m_state)
      0: if (ed[5]) restart = 1;
      1: begin
        if (game_over) n_state = 3;
        else if (ed[4]) n_state = 2;
        else if (m_cnt >= p - 1) begin tick = 1; n_cnt = 0; end
        else n_cnt = m_cnt + 1;
      end
      2: begin
        if (ed[5]) restart = 1;
        else if (ed[4]) begin n_state = 1; n_cnt = m_cnt + 1; end
      end
      default: begin flush = 1; if (ed[5]) restart = 1; end
    endcase
    e.st = 2'(m_state); e.tick = tick; e.rst = m_rst; e.dir = m_dir;
    rv = |ed[3:0];
    if (ed[3]) r = 2'b01;
    else if (ed[2]) r = 2'b11;
    else if (ed[1]) r = 2'b10;
    else r = 2'b00;
    refd = (mq.size() > 0) ? mq[$] : m_dir;
    popping = tick && (mq.size() > 0);
    accept = (m_state == 1) && rv && (r != refd) && (r != (refd ^ 2'b10)) &&
             ((mq.size() < 2) || popping);
    if (popping) n_dir = mq.pop_front();
    if (accept) mq.push_back(r);
    if (restart) begin n_state = 1; n_cnt = 0; n_rst = 1; n_dir = 2'b00; flush = 1; end
    if (flush) mq.delete();
    m_state = n_state; m_cnt = n_cnt; m_dir = n_dir; m_rst = n_rst; m_prev = now;
  endtask

  // One clock: model predicts, DUT is sampled at negedge, then the edge is taken.
  task automatic step();
    exp_t e, g;
    @(negedge clk_100MHz);
    model_cycle(e);
    sb.push_back(e);
    g = sb.pop_front();
    last_tick = game_tick;
    n_assert++;
    if (state !== g.st || game_tick !== g.tick || game_rst !== g.rst || snake_direction !== g.dir) begin
      n_fail++;
      $display("FAIL cycle: got st=%0d tick=%0d rst=%0d dir=%0d expected st=%0d tick=%0d rst=%0d dir=%0d at %0t",
               state, game_tick, game_rst, snake_direction, g.st, g.tick, g.rst, g.dir, $time);
    end
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic do_reset();
    {btn_start, btn_pause, btn_up, btn_down, btn_left, btn_right} = '0;
    game_over = 0;
    score = 8'd0;
    reset = 1;
    model_reset();
    #2;
    @(posedge clk_100MHz);
    #1;
    reset = 0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!last_tick && n < 300);
    if (!last_tick) chk("tick_timeout", n, -1);
  endtask

  task automatic press(input logic [3:0] m);
    {btn_up, btn_down, btn_left, btn_right} = m;
    step();
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    step();
  endtask

  task automatic start_game();
    btn_start = 1;
    step();
    btn_start = 0;
    step();
  endtask

  turn_t tv[7];

  initial begin
    int n, n2, ticks;
    tv[0] = '{m1:4'b1000, m2:4'b0010, m3:4'b0100, e1:2'b01, e2:2'b10, e3:2'b10};
    tv[1] = '{m1:4'b0010, m2:4'b0000, m3:4'b0000, e1:2'b00, e2:2'b00, e3:2'b00};
    tv[2] = '{m1:4'b0001, m2:4'b0000, m3:4'b0000, e1:2'b00, e2:2'b00, e3:2'b00};
    tv[3] = '{m1:4'b1001, m2:4'b0000, m3:4'b0000, e1:2'b01, e2:2'b01, e3:2'b01};
    tv[4] = '{m1:4'b0100, m2:4'b1000, m3:4'b0000, e1:2'b11, e2:2'b11, e3:2'b11};
    tv[5] = '{m1:4'b1000, m2:4'b0100, m3:4'b0000, e1:2'b01, e2:2'b01, e3:2'b01};
    tv[6] = '{m1:4'b1000, m2:4'b0001, m3:4'b0000, e1:2'b01, e2:2'b00, e3:2'b00};

    // reset state and start
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_tick", game_tick, 0);
    chk("rst_grst", game_rst, 0);
    chk("rst_dir", snake_direction, 0);
    btn_start = 1;
    step();
    chk("start_grst", game_rst, 1);
    chk("start_state", state, 1);
    step();
    chk("grst_one_cycle", game_rst, 0);
    wait_tick(n);
    wait_tick(n);  chk("period_s0", n, 20);
    wait_tick(n);  chk("period_s0_b", n, 20);
    chk("dir_play", snake_direction, 0);
    btn_start = 0;

    // score scaling
    score = 8'd3;   wait_tick(n);  chk("period_s3", n, 14);
    score = 8'd10;  wait_tick(n);  chk("period_s10", n, 8);
    score = 8'd200; wait_tick(n);  chk("period_s200", n, 8);
    wait_tick(n);   chk("period_s200_b", n, 8);
    score = 8'd10;  wait_tick(n);
    step(); step();
    score = 8'd0;   wait_tick(n2); chk("period_drop", n + 0 * n2 + n2 - n + 2, 20);

    // turn queue table
    for (int i = 0; i < 7; i++) begin
      do_reset();
      start_game();
      press(tv[i].m1);
      press(tv[i].m2);
      press(tv[i].m3);
      wait_tick(n); chk($sformatf("turn%0d_t1", i), snake_direction, tv[i].e1);
      wait_tick(n); chk($sformatf("turn%0d_t2", i), snake_direction, tv[i].e2);
      wait_tick(n); chk($sformatf("turn%0d_t3", i), snake_direction, tv[i].e3);
    end

    // pause at counter 7, presses ignored, resume
    do_reset();
    start_game();
    wait_tick(n);
    repeat (7) step();
    btn_pause = 1;
    step();
    chk("pause_state", state, 2);
    ticks = 0;
    for (int k = 0; k < 100; k++) begin
      if (k == 3) btn_pause = 0;
      {btn_up, btn_down, btn_left, btn_right} = (k % 4 == 1) ? 4'b1000 : 4'b0000;
      step();
      if (last_tick) ticks++;
    end
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    chk("pause_no_ticks", ticks, 0);
    btn_pause = 1;
    step();
    chk("resume_state", state, 1);
    wait_tick(n);  chk("resume_latency", n, 12);
    chk("pause_presses_ignored", snake_direction, 0);
    btn_pause = 0;

    // game_over + pause edge with tick due
    wait_tick(n);
    repeat (19) step();
    game_over = 1; btn_pause = 1;
    step();
    chk("over_tick_suppressed", last_tick, 0);
    chk("over_state", state, 3);
    game_over = 0; btn_pause = 0;
    step();
    btn_start = 1;
    step();
    chk("restart_grst", game_rst, 1);
    chk("restart_state", state, 1);
    chk("restart_dir", snake_direction, 0);
    btn_start = 0;
    press(4'b1000);
    wait_tick(n);
    chk("restart_queue_dir", snake_direction, 1);
    press(4'b0010);
    repeat (3) step();
    #2 reset = 1;
    #1;
    chk("async_state", state, 0);
    chk("async_tick", game_tick, 0);
    chk("async_dir", snake_direction, 0);
    chk("async_grst", game_rst, 0);
    model_reset();
    @(posedge clk_100MHz);
    #1 reset = 0;
    chk("after_reset_idle", state, 0);

    // randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 29) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 19) == 0) btn_pause = ~btn_pause;
      if ($urandom_range(0, 79) == 0) game_over = ~game_over;
      if ($urandom_range(0, 3) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 3) == 0) btn_down = ~btn_down;
      if ($urandom_range(0, 3) == 0) btn_left = ~btn_left;
      if ($urandom_range(0, 3) == 0) btn_right = ~btn_right;
      if ($urandom_range(0, 49) == 0) score = 8'($urandom_range(0, 12));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
Session controller and move scheduler for the snake game datapath. It owns the game life-cycle (idle, play, pause, over) and generates the one-cycle game_tick strobe. The tick period shortens as score rises. It also buffers player turn requests in a 2-deep queue so quick double turns are not lost between ticks. It drives the game datapath's game_tick, snake_direction and a synchronous game_rst pulse, and reads back score and game_over.

Parameters:
BASE_TICK, 10000000, tick period in clk cycles at score 0 (10 Hz)
STEP_TICK, 500000, period reduction per score point
MIN_TICK, 2000000, floor on tick period; must be >= 2
CNT_W, 24, tick counter width; must hold BASE_TICK-1

Ports:
clk_100MHz  in  1  system clock
reset  in  1  asynchronous, active-high
btn_start  in  1  start/restart, debounced level
btn_pause  in  1  pause toggle, debounced level
btn_up  in  1  debounced level
btn_down  in  1  debounced level
btn_left  in  1  debounced level
btn_right  in  1  debounced level
game_over  in  1  level from game datapath
score  in  8  current score from game datapath
game_tick  out  1  one-cycle move strobe
snake_direction  out  2  00 right, 01 up, 10 left, 11 down
game_rst  out  1  one-cycle synchronous restart pulse to datapath
state  out  2  00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER

Behaviour:
- Reset, asynchronous and active-high: state=IDLE, game_tick=0, game_rst=0, snake_direction=00, tick counter=0, queue empty, button history regs=0.
- Every button is rising-edge detected (cur & ~prev, registered prev). Levels held high never retrigger.
- Period P = max(MIN_TICK, BASE_TICK - score*STEP_TICK). Compute in 32 bits with no underflow: if score*STEP_TICK >= BASE_TICK - MIN_TICK, then P = MIN_TICK. P is recomputed every cycle.
- IDLE: no ticks. On start edge: game_rst=1 for one cycle; counter cleared; queue flushed; snake_direction=00; next state PLAY.
- PLAY:
  - counter increments each cycle.
  - When counter >= P-1: game_tick=1 for one cycle and counter=0. The >= comparison handles P shrinking mid-count.
  - game_over=1: go to OVER and suppress game_tick in that cycle. This takes priority over pause.
  - Pause edge: go to PAUSE with the counter frozen. A tick due in the same cycle is suppressed, and the counter holds at its value.
- PAUSE: no ticks; counter held; direction edges ignored (not queued). Pause edge returns to PLAY and counting resumes from the held value. Start edge acts as restart: same actions as from IDLE.
- OVER: no ticks; queue flushed. Start edge acts as restart.
- Start edge in PLAY is ignored.
- If start and pause edges occur in the same cycle, start wins.
- Turn queue (PLAY only), 2 entries, FIFO:
  - At most one push per cycle. If several direction edges occur together, priority is up > down > left > right.
  - Reference dir = newest queued entry if the queue is non-empty, else snake_direction.
  - A request is dropped if it equals the reference dir or is its reverse (00<->10, 01<->11).
  - A request is dropped if the queue is full, unless a pop happens in the same cycle.
  - Pop occurs on each game_tick cycle when the queue is non-empty. snake_direction takes the head value on the cycle after game_tick, so the datapath uses it on the next tick.
  - Push and pop in the same cycle: count is unchanged. The reference dir is still evaluated on the pre-pop contents.
- game_rst never coincides with game_tick.
- Reset mid-operation aborts everything immediately: the queue is lost and no pulses are emitted.

Test Plan:
Run with BASE_TICK=20, STEP_TICK=2, MIN_TICK=8, CNT_W=8.
1. Reset, then a start edge → game_rst high exactly 1 cycle, state=01. game_tick pulses every 20 cycles with score=0; snake_direction=00.
2. Set score=3 → period 14. Set score=10 → period 8 (floor). Set score=200 → period stays 8 with no wrap. Drop score from 10 to 0 mid-count → next tick exactly 20 cycles after the previous one.
3. In PLAY with dir 00, press up then left between ticks → after tick 1 snake_direction=01, after tick 2 snake_direction=10. A third press (down) while the queue is full is dropped.
4. Dir 00: press left → dropped (reverse). Press right → dropped (same). Press up+right together → up queued.
5. Pause edge at counter=7 → state=10 with no ticks for 100 cycles and direction presses ignored. Second pause edge → first tick 12 cycles later.
6. game_over high in the same cycle as pause edge and tick due → state=11, no tick. Start edge → game_rst pulse, state=01, queue empty, dir=00. Assert reset during PLAY → all outputs return to reset values asynchronously.
